vector_adder_pipe: RTL and testbench

Pipelined, multi-lane add/subtract unit for the ASIP datapath and the successor of the single-lane combinational vector adder. It splits a packed vector into `LANES` independent elements of `WIDTH` bits and applies one of four operations to every lane: add, subtract, saturating add or saturating subtract. Each lane reports a real carry/borrow flag. The unit runs as a two-stage valid/ready pipeline with full backpressure and keeps a running count of carry/borrow events for the core's status registers.

---
 rtl/adder_v_pkg.sv | 14 +
 rtl/adder_lane.sv | 56 +++++
 rtl/vector_adder_pipe.sv | 132 +++++++++++++
 tb/tb_vector_adder_pipe.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_v_pkg.sv
// Shared types for the pipelined vector adder.
// Holds the per-lane operation encoding and the fixed pipeline depth.
package adder_v_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDS = 2'b10,
        OP_SUBS = 2'b11
    } op_t;

    localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/adder_lane.sv
// One combinational add/subtract lane (no state).
// Ports: a, b (WIDTH), op (op_t) -> result (WIDTH), carry (carry or borrow).
// Saturating codes only saturate when VECTOR_ADDER_SAT_EN is defined.
module adder_lane
    import adder_v_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;

    // The extra MSB of the widened difference is the unsigned borrow.
    always_comb begin
        sum_w  = {1'b0, a} + {1'b0, b};
        diff_w = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        unique case (op)
            OP_ADD: begin
                result = sum_w[WIDTH-1:0];
                carry  = sum_w[WIDTH];
            end
            OP_SUB: begin
                result = diff_w[WIDTH-1:0];
                carry  = diff_w[WIDTH];
            end
`ifdef VECTOR_ADDER_SAT_EN
            OP_ADDS: begin
                result = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
                carry  = sum_w[WIDTH];
            end
            OP_SUBS: begin
                result = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
                carry  = diff_w[WIDTH];
            end
`else
            OP_ADDS: begin
                result = sum_w[WIDTH-1:0];
                carry  = sum_w[WIDTH];
            end
            OP_SUBS: begin
                result = diff_w[WIDTH-1:0];
                carry  = diff_w[WIDTH];
            end
`endif
        endcase
    end

endmodule

// File: rtl/vector_adder_pipe.sv
// Two-stage valid/ready multi-lane add/sub unit with carry-event counter.
// Ports: clk, rst_n, in_valid/in_ready, a, b, selector -> stage 1;
//        out_valid/out_ready, result, carry_out <- stage 2;
//        clr_count, carry_count (saturating). Option: VECTOR_ADDER_SAT_EN.
module vector_adder_pipe
    import adder_v_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [1:0]             selector,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       carry_out,
    input  logic                   clr_count,
    output logic [CNT_W-1:0]       carry_count
);

    localparam int VW = LANES * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [VW-1:0]    a_q, a_d;
    logic [VW-1:0]    b_q, b_d;
    op_t              op_q, op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [VW-1:0]    res_q, res_d;
    logic [LANES-1:0] cy_q, cy_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s1_advance;
    logic             accept;
    logic             fire;
    logic [VW-1:0]    lane_res;
    logic [LANES-1:0] lane_cy;

    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign accept     = in_valid && in_ready;
    assign fire       = s2_valid_q && out_ready && (|cy_q);

    // Lanes compute from the stage-1 registers; stage 2 captures them.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        adder_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .a     (a_q[i*WIDTH +: WIDTH]),
            .b     (b_q[i*WIDTH +: WIDTH]),
            .op    (op_q),
            .result(lane_res[i*WIDTH +: WIDTH]),
            .carry (lane_cy[i])
        );
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = a;
            b_d        = b;
            op_d       = op_t'(selector);
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 reloads whenever stage 1 may advance, so a drain and a
    // fill on the same edge leave no bubble.
    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        cy_d       = cy_q;
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = lane_res;
                cy_d  = lane_cy;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at max.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            cy_q       <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            cy_q       <= cy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign result      = res_q;
    assign carry_out   = cy_q;
    assign carry_count = cnt_q;

endmodule

// File: tb/tb_vector_adder_pipe.sv
// Self-checking bench for vector_adder_pipe (4x8 main, 2x8 small-counter).
// Randomized streams are scored against a per-lane arithmetic model.
module tb_vector_adder_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  carry_out;
    logic        clr_count;
    logic [15:0] carry_count;

    logic        d2_in_valid;
    logic        d2_in_ready;
    logic [15:0] d2_a;
    logic [15:0] d2_b;
    logic [1:0]  d2_sel;
    logic        d2_out_valid;
    logic        d2_out_ready;
    logic [15:0] d2_result;
    logic [1:0]  d2_carry_out;
    logic        d2_clr_count;
    logic [3:0]  d2_carry_count;

    int n_cmp;
    int n_err;
    int cnt_exp;

    vector_adder_pipe #(.LANES(4), .WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .selector(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out),
        .clr_count(clr_count), .carry_count(carry_count)
    );

    vector_adder_pipe #(.LANES(2), .WIDTH(8), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .a(d2_a), .b(d2_b), .selector(d2_sel),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .result(d2_result), .carry_out(d2_carry_out),
        .clr_count(d2_clr_count), .carry_count(d2_carry_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: plain integer arithmetic per 8-bit lane.
    function automatic void ref_model(
        input  logic [31:0] av,
        input  logic [31:0] bv,
        input  logic [1:0]  s,
        output logic [31:0] r,
        output logic [3:0]  c
    );
        bit sat;
`ifdef VECTOR_ADDER_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        r = '0;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            int x;
            int y;
            int t;
            x = int'(av[i*8 +: 8]);
            y = int'(bv[i*8 +: 8]);
            if (s[0] == 1'b0) begin
                t = x + y;
                c[i] = (t >= 256);
                t = t % 256;
                if (sat && s[1] && c[i]) t = 255;
            end else begin
                c[i] = (x < y);
                t = (x - y + 256) % 256;
                if (sat && s[1] && c[i]) t = 0;
            end
            r[i*8 +: 8] = 8'(t);
        end
    endfunction

    task automatic send_beat(
        input  logic [31:0] av,
        input  logic [31:0] bv,
        input  logic [1:0]  s,
        output logic [31:0] r,
        output logic [3:0]  c,
        output bit          ok
    );
        ok = 1'b0;
        r  = '0;
        c  = '0;
        @(negedge clk);
        a = av; b = bv; sel = s;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                r  = result;
                c  = carry_out;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; clr_count = 0;
        a = '0; b = '0; sel = '0;
        d2_in_valid = 0; d2_out_ready = 0; d2_clr_count = 0;
        d2_a = '0; d2_b = '0; d2_sel = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 32'h0 || carry_out !== 4'h0
            || carry_count !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state: ov=%b res=%h cy=%b cnt=%h want 0",
                     out_valid, result, carry_out, carry_count);
        end
        n_cmp++;
        if (d2_out_valid !== 1'b0 || d2_carry_count !== 4'h0) begin
            n_err++;
            $display("FAIL reset_state2: ov=%b cnt=%h want 0",
                     d2_out_valid, d2_carry_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_directed();
        @(negedge clk);
        a = 32'h01FF8010; b = 32'h01018005; sel = 2'b00;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL add_accept: in_ready %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_latency_early: out_valid %b want 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || result !== 32'h02000015 || carry_out !== 4'b0110) begin
            n_err++;
            $display("FAIL add_result: ov=%b res=%h cy=%b want 1 02000015 0110",
                     out_valid, result, carry_out);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || carry_count !== 16'd1) begin
            n_err++;
            $display("FAIL add_count: ov=%b cnt=%0d want 0 1", out_valid, carry_count);
        end
    endtask

    task automatic test_sub_sat();
        logic [31:0] r;
        logic [3:0]  c;
        logic [31:0] er;
        logic [3:0]  ec;
        bit          ok;
        send_beat(32'h00000500, 32'h00000301, 2'b01, r, c, ok);
        n_cmp++;
        if (!ok || r !== 32'h000002FF || c !== 4'b0001) begin
            n_err++;
            $display("FAIL sub: ok=%b res=%h cy=%b want 000002ff 0001", ok, r, c);
        end
`ifdef VECTOR_ADDER_SAT_EN
        er = 32'h000000FF;
`else
        er = 32'h00000010;
`endif
        send_beat(32'h000000F0, 32'h00000020, 2'b10, r, c, ok);
        n_cmp++;
        if (!ok || r !== er || c !== 4'b0001) begin
            n_err++;
            $display("FAIL adds: ok=%b res=%h cy=%b want %h 0001", ok, r, c, er);
        end
`ifdef VECTOR_ADDER_SAT_EN
        er = 32'h00000000;
`else
        er = 32'h000000F0;
`endif
        send_beat(32'h00000010, 32'h00000020, 2'b11, r, c, ok);
        n_cmp++;
        if (!ok || r !== er || c !== 4'b0001) begin
            n_err++;
            $display("FAIL subs: ok=%b res=%h cy=%b want %h 0001", ok, r, c, er);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] av;
            logic [31:0] bv;
            logic [1:0]  s;
            av = $urandom; bv = $urandom; s = 2'(i % 4);
            ref_model(av, bv, s, er, ec);
            send_beat(av, bv, s, r, c, ok);
            n_cmp++;
            if (!ok || r !== er || c !== ec) begin
                n_err++;
                $display("FAIL single_rand op=%0d: ok=%b res=%h cy=%b want %h %b",
                         s, ok, r, c, er, ec);
            end
        end
    endtask

    // mode 0: back-to-back with out_ready 1,0,0,1; mode 1: fully random.
    task automatic test_stream(input string name, input int nbeats, input int mode);
        logic [31:0] q_r[$];
        logic [3:0]  q_c[$];
        logic [31:0] er;
        logic [3:0]  ec;
        logic [31:0] hold_r;
        logic [3:0]  hold_c;
        bit          stalled;
        bit          saw_full;
        bit          exp_ir;
        int          sent;
        int          got;
        int          cyc;
        @(negedge clk);
        in_valid = 0; out_ready = 1; clr_count = 1;
        @(negedge clk);
        clr_count = 0;
        cnt_exp = 0;
        sent = 0; got = 0; cyc = 0;
        stalled = 0; saw_full = 0;
        hold_r = '0; hold_c = '0;
        while (got < nbeats && cyc < 3000) begin
            @(negedge clk);
            if (mode == 0) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else out_ready = 1'($urandom_range(0, 1));
            if (sent < nbeats) begin
                in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
                a = $urandom; b = $urandom; sel = 2'($urandom_range(0, 3));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_ir = (q_r.size() < 2) || out_ready;
            if (!in_ready) saw_full = 1'b1;
            n_cmp++;
            if (in_ready !== exp_ir) begin
                n_err++;
                $display("FAIL %s in_ready cyc %0d: got %b want %b", name, cyc, in_ready, exp_ir);
            end
            n_cmp++;
            if (carry_count !== 16'(cnt_exp)) begin
                n_err++;
                $display("FAIL %s count cyc %0d: got %0d want %0d",
                         name, cyc, carry_count, cnt_exp);
            end
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || result !== hold_r || carry_out !== hold_c) begin
                    n_err++;
                    $display("FAIL %s stall_stable cyc %0d: ov=%b res=%h cy=%b want 1 %h %b",
                             name, cyc, out_valid, result, carry_out, hold_r, hold_c);
                end
            end
            if (out_valid === 1'b1) begin
                if (q_r.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s spurious_out cyc %0d: res=%h", name, cyc, result);
                end else if (out_ready) begin
                    er = q_r.pop_front();
                    ec = q_c.pop_front();
                    n_cmp++;
                    if (result !== er || carry_out !== ec) begin
                        n_err++;
                        $display("FAIL %s beat %0d: res=%h cy=%b want %h %b",
                                 name, got, result, carry_out, er, ec);
                    end
                    if (|ec && cnt_exp < 65535) cnt_exp++;
                    got++;
                end
            end
            stalled = out_valid && !out_ready;
            hold_r  = result;
            hold_c  = carry_out;
            if (in_valid && in_ready) begin
                ref_model(a, b, sel, er, ec);
                q_r.push_back(er);
                q_c.push_back(ec);
                sent++;
            end
            cyc++;
        end
        n_cmp++;
        if (got != nbeats) begin
            n_err++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, got, nbeats);
        end
        if (mode == 0) begin
            n_cmp++;
            if (!saw_full) begin
                n_err++;
                $display("FAIL %s in_ready_drop: never low, want low when full", name);
            end
        end
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        #1;
        n_cmp++;
        if (carry_count !== 16'(cnt_exp) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s final: cnt=%0d ov=%b want %0d 0",
                     name, carry_count, out_valid, cnt_exp);
        end
    endtask

    task automatic test_small_lanes();
        bit ok;
        @(negedge clk);
        d2_a = 16'h0500; d2_b = 16'h0301; d2_sel = 2'b01;
        d2_in_valid = 1; d2_out_ready = 1;
        @(negedge clk);
        d2_in_valid = 0;
        ok = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (d2_out_valid) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok || d2_result !== 16'h02FF || d2_carry_out !== 2'b01) begin
            n_err++;
            $display("FAIL sub_2lane: ok=%b res=%h cy=%b want 02ff 01",
                     ok, d2_result, d2_carry_out);
        end
    endtask

    task automatic test_count_sat();
        @(negedge clk);
        d2_a = 16'hFFFF; d2_b = 16'h0101; d2_sel = 2'b00;
        d2_out_ready = 1; d2_in_valid = 1;
        repeat (20) @(negedge clk);
        d2_in_valid = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (d2_carry_count !== 4'hF) begin
            n_err++;
            $display("FAIL count_sat: got %h want f", d2_carry_count);
        end
        @(negedge clk);
        d2_in_valid = 1;
        @(negedge clk);
        d2_in_valid = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (d2_carry_count !== 4'hF) begin
            n_err++;
            $display("FAIL count_hold: got %h want f", d2_carry_count);
        end
        // Clear lands on the same edge as a completing carry beat.
        @(negedge clk);
        d2_in_valid = 1;
        @(negedge clk);
        d2_in_valid = 0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (d2_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL clr_setup: out_valid %b want 1", d2_out_valid);
        end
        d2_clr_count = 1;
        @(negedge clk);
        d2_clr_count = 0;
        #1;
        n_cmp++;
        if (d2_carry_count !== 4'h0 || d2_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_priority: cnt=%h ov=%b want 0 0", d2_carry_count, d2_out_valid);
        end
        @(negedge clk);
        d2_in_valid = 1;
        @(negedge clk);
        d2_in_valid = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (d2_carry_count !== 4'h1) begin
            n_err++;
            $display("FAIL count_after_clr: got %h want 1", d2_carry_count);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 0;
        a = 32'h11223344; b = 32'hF0F0F0F0; sel = 2'b00; in_valid = 1;
        @(negedge clk);
        a = 32'h55667788;
        @(negedge clk);
        in_valid = 0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_pipe: ov=%b ir=%b want 1 0", out_valid, in_ready);
        end
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 32'h0 || carry_out !== 4'h0
            || carry_count !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid: ov=%b res=%h cy=%b cnt=%h want 0",
                     out_valid, result, carry_out, carry_count);
        end
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_release cyc %0d: ov=%b ir=%b want 0 1",
                         k, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cnt_exp = 0;
        test_reset();
        test_add_directed();
        test_sub_sat();
        test_stream("back_to_back", 6, 0);
        test_stream("random_stream", 300, 1);
        test_small_lanes();
        test_count_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
